// File: rtl/twiddle_seq.sv
// Streaming FFT twiddle-factor sequencer. It walks an N1 x N2 grid in row-major order
// and emits W_N^(n1*k2) as single-precision pairs rebuilt from a quarter-wave cosine table.
module twiddle_seq #(
  parameter int LOG2_N  = 4,
  parameter int LOG2_N2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tbl_we,
  input  logic [LOG2_N-2:0] tbl_addr,
  input  logic [31:0]       tbl_data,
  input  logic              start,
  input  logic              inverse,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_wr,
  output logic [31:0]       out_wi,
  output logic [LOG2_N-1:0] out_idx,
  output logic              out_last
);
  localparam int N  = 1 << LOG2_N;
  localparam int AW = LOG2_N - 1;
  localparam int L1 = LOG2_N - LOG2_N2;
  localparam logic [AW-1:0] QTR = AW'(N / 4);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               inv_q;
  logic [L1-1:0]      n1_q, n1_d, cur_n1;
  logic [LOG2_N2-1:0] k2_q, k2_d, cur_k2;
  logic [LOG2_N-1:0]  e_q, e_d, cur_e;
  logic               advance, issue, cur_last, accept_last;
  logic [AW-1:0]      r_d;

  logic               s1_valid_q, s1_last_q;
  logic [1:0]         s1_quad_q;
  logic [AW-1:0]      s1_r_q, s1_qr_q;
  logic [LOG2_N-1:0]  s1_idx_q;

  logic [31:0]        cos_w, sin_w, wr_d, wi_d;
  logic [31:0]        tbl_q [0:N/4];

  // Any zero magnitude leaves as +0 so the multiplier never sees -0.
  function automatic logic [31:0] canon(input logic [31:0] w);
    return (w[30:0] == 31'd0) ? 32'h0000_0000 : w;
  endfunction

  assign busy = (state_q != ST_IDLE);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    advance     = !out_valid || out_ready;
    issue       = advance && ((state_q == ST_IDLE && start) || state_q == ST_RUN);
    cur_n1      = (state_q == ST_IDLE) ? '0 : n1_q;
    cur_k2      = (state_q == ST_IDLE) ? '0 : k2_q;
    cur_e       = (state_q == ST_IDLE) ? '0 : e_q;
    cur_last    = (&cur_n1) && (&cur_k2);
    accept_last = out_valid && out_ready && out_last;
    r_d         = AW'(cur_e) & (QTR - 1'b1);

    n1_d = n1_q;
    k2_d = k2_q;
    e_d  = e_q;
    if (issue) begin
      if (&cur_k2) begin
        k2_d = '0;
        n1_d = cur_n1 + 1'b1;
        e_d  = '0;
      end else begin
        k2_d = cur_k2 + 1'b1;
        n1_d = cur_n1;
        e_d  = cur_e + LOG2_N'(cur_n1);
      end
    end

    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (issue) state_d = ST_RUN;
      ST_RUN:   if (issue && cur_last) state_d = ST_DRAIN;
      ST_DRAIN: if (accept_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Odd quadrants swap the roles of r and N/4-r; the quadrant bits set the signs.
  always_comb begin
    cos_w = tbl_q[s1_quad_q[0] ? s1_qr_q : s1_r_q];
    sin_w = tbl_q[s1_quad_q[0] ? s1_r_q : s1_qr_q];
    wr_d  = canon({cos_w[31] ^ s1_quad_q[1] ^ s1_quad_q[0], cos_w[30:0]});
    wi_d  = canon({sin_w[31] ^ s1_quad_q[1] ^ ~inv_q, sin_w[30:0]});
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      inv_q      <= 1'b0;
      n1_q       <= '0;
      k2_q       <= '0;
      e_q        <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_quad_q  <= '0;
      s1_r_q     <= '0;
      s1_qr_q    <= '0;
      s1_idx_q   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_wr     <= '0;
      out_wi     <= '0;
      out_idx    <= '0;
    end else begin
      state_q <= state_d;
      n1_q    <= n1_d;
      k2_q    <= k2_d;
      e_q     <= e_d;
      if (state_q == ST_IDLE && issue) inv_q <= inverse;
      if (advance) begin
        s1_valid_q <= issue;
        if (issue) begin
          s1_quad_q <= cur_e[LOG2_N-1 -: 2];
          s1_r_q    <= r_d;
          s1_qr_q   <= QTR - r_d;
          s1_idx_q  <= {cur_n1, cur_k2};
          s1_last_q <= cur_last;
        end
        out_valid <= s1_valid_q;
        out_last  <= s1_valid_q && s1_last_q;
        if (s1_valid_q) begin
          out_wr  <= wr_d;
          out_wi  <= wi_d;
          out_idx <= s1_idx_q;
        end
      end
    end
  end

  // NOTE: the coefficient table has no reset on purpose; its contents survive rst.
  always_ff @(posedge clk) begin
    if (tbl_we && !busy && tbl_addr <= QTR) tbl_q[tbl_addr] <= tbl_data;
  end

endmodule

// File: tb/tb_twiddle_seq.sv
// Directed bench for twiddle_seq: N=16 frames (forward, inverse, stall, hazards, reset)
// plus an N=64 instance checked element-by-element against a floating-point model.
module tb_twiddle_seq;
  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  // N=16 instance
  logic        a_tbl_we, a_start, a_inverse, a_busy, a_out_valid, a_out_ready, a_out_last;
  logic [2:0]  a_tbl_addr;
  logic [31:0] a_tbl_data, a_out_wr, a_out_wi;
  logic [3:0]  a_out_idx;

  // N=64 instance
  logic        b_tbl_we, b_start, b_inverse, b_busy, b_out_valid, b_out_ready, b_out_last;
  logic [4:0]  b_tbl_addr;
  logic [31:0] b_tbl_data, b_out_wr, b_out_wi;
  logic [5:0]  b_out_idx;

  twiddle_seq #(.LOG2_N(4), .LOG2_N2(2)) dut_a (
    .clk(clk), .rst(rst), .tbl_we(a_tbl_we), .tbl_addr(a_tbl_addr), .tbl_data(a_tbl_data),
    .start(a_start), .inverse(a_inverse), .busy(a_busy), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_wr(a_out_wr), .out_wi(a_out_wi), .out_idx(a_out_idx),
    .out_last(a_out_last)
  );

  twiddle_seq #(.LOG2_N(6), .LOG2_N2(3)) dut_b (
    .clk(clk), .rst(rst), .tbl_we(b_tbl_we), .tbl_addr(b_tbl_addr), .tbl_data(b_tbl_data),
    .start(b_start), .inverse(b_inverse), .busy(b_busy), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_wr(b_out_wr), .out_wi(b_out_wi), .out_idx(b_out_idx),
    .out_last(b_out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Hand-computed forward frame for N=16, N2=4.
  logic [31:0] exp_wr [16];
  logic [31:0] exp_wi [16];

  // Frame capture shared by the N=16 tests.
  logic [31:0] cap_wr [64];
  logic [31:0] cap_wi [64];
  logic [3:0]  cap_idx [64];
  logic        cap_last [64];
  int          cap_n, first_cyc, fall_cyc, t0, timed_out;
  logic [31:0] stall_wr [8];
  logic [31:0] stall_wi [8];
  logic [3:0]  stall_idx [8];
  int          stall_n;

  function automatic logic [31:0] to_single(input real v);
    logic [63:0] b;
    logic [23:0] m;
    logic [28:0] rem;
    int          ex;
    if (v < 1.0e-9 && v > -1.0e-9) return 32'h0000_0000;
    b   = $realtobits(v);
    ex  = int'(b[62:52]) - 1023 + 127;
    m   = {1'b0, b[51:29]};
    rem = b[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && m[0])) m = m + 24'd1;
    if (m[23]) begin
      ex = ex + 1;
      m  = 24'd0;
    end
    return {b[63], ex[7:0], m[22:0]};
  endfunction

  task automatic load_a(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    a_tbl_we = 1'b1; a_tbl_addr = addr; a_tbl_data = data;
    @(negedge clk);
    a_tbl_we = 1'b0;
  endtask

  task automatic do_frame(input logic inv, input int stall_at, input int stall_len,
                          input bit hazard, input bit we_start,
                          input logic [2:0] we_addr, input logic [31:0] we_data);
    int stall_left;
    bit stalled;
    cap_n = 0; stall_n = 0; first_cyc = -1; fall_cyc = -1; timed_out = 0;
    stall_left = 0; stalled = 0;
    @(negedge clk);
    t0 = cyc;
    a_start = 1'b1; a_inverse = inv; a_out_ready = 1'b1;
    if (we_start) begin
      a_tbl_we = 1'b1; a_tbl_addr = we_addr; a_tbl_data = we_data;
    end
    @(negedge clk);
    a_start = 1'b0; a_inverse = 1'b0; a_tbl_we = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (!a_busy) begin
        fall_cyc = cyc;
        break;
      end
      a_start = 1'b0; a_tbl_we = 1'b0; a_out_ready = 1'b1;
      if (a_out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (!stalled && int'(a_out_idx) == stall_at) begin
          stalled = 1; stall_left = stall_len;
        end
        if (hazard && (a_out_idx == 4'd8 || a_out_last)) a_start = 1'b1;
        if (hazard && a_out_idx == 4'd8) begin
          a_tbl_we = 1'b1; a_tbl_addr = 3'd1; a_tbl_data = 32'hdead_beef;
        end
        if (stall_left > 0) begin
          a_out_ready = 1'b0;
          stall_left--;
          if (stall_n < 8) begin
            stall_wr[stall_n] = a_out_wr; stall_wi[stall_n] = a_out_wi;
            stall_idx[stall_n] = a_out_idx; stall_n++;
          end
        end else if (cap_n < 64) begin
          cap_wr[cap_n] = a_out_wr; cap_wi[cap_n] = a_out_wi;
          cap_idx[cap_n] = a_out_idx; cap_last[cap_n] = a_out_last; cap_n++;
        end
      end
      @(negedge clk);
    end
    if (fall_cyc < 0) timed_out = 1;
    a_start = 1'b0; a_tbl_we = 1'b0; a_out_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (a_busy !== 1'b0 || a_out_valid !== 1'b0 || a_out_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl busy=%b valid=%b last=%b want 0 0 0", a_busy, a_out_valid, a_out_last);
    end
    checks++;
    if (a_out_wr !== 32'h0 || a_out_wi !== 32'h0 || a_out_idx !== 4'h0) begin
      failures++;
      $display("FAIL reset_data wr=%h wi=%h idx=%0d want 0 0 0", a_out_wr, a_out_wi, a_out_idx);
    end
    checks++;
    if (b_busy !== 1'b0 || b_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_b busy=%b valid=%b want 0 0", b_busy, b_out_valid);
    end
    rst = 1'b0;
  endtask

  task automatic test_forward;
    do_frame(1'b0, -1, 0, 1'b0, 1'b0, 3'd0, 32'h0);
    checks++;
    if (timed_out != 0 || cap_n != 16) begin
      failures++;
      $display("FAIL fwd_count got=%0d want=16 timeout=%0d", cap_n, timed_out);
    end
    for (int i = 0; i < 16 && i < cap_n; i++) begin
      checks++;
      if (cap_idx[i] !== 4'(i) || cap_wr[i] !== exp_wr[i] || cap_wi[i] !== exp_wi[i]
          || cap_last[i] !== (i == 15)) begin
        failures++;
        $display("FAIL fwd_elem %0d got idx=%0d wr=%h wi=%h last=%b want idx=%0d wr=%h wi=%h last=%b",
                 i, cap_idx[i], cap_wr[i], cap_wi[i], cap_last[i], i, exp_wr[i], exp_wi[i], i == 15);
      end
    end
    checks++;
    if (first_cyc != t0 + 2) begin
      failures++;
      $display("FAIL fwd_first_valid got=t+%0d want=t+2", first_cyc - t0);
    end
    checks++;
    if (fall_cyc != t0 + 18) begin
      failures++;
      $display("FAIL fwd_busy_fall got=t+%0d want=t+18", fall_cyc - t0);
    end
  endtask

  task automatic test_inverse;
    logic [31:0] want_wi;
    do_frame(1'b1, -1, 0, 1'b0, 1'b0, 3'd0, 32'h0);
    checks++;
    if (cap_n != 16) begin
      failures++;
      $display("FAIL inv_count got=%0d want=16", cap_n);
    end
    for (int i = 0; i < 16 && i < cap_n; i++) begin
      want_wi = (exp_wi[i] == 32'h0) ? 32'h0 : (exp_wi[i] ^ 32'h8000_0000);
      checks++;
      if (cap_wr[i] !== exp_wr[i] || cap_wi[i] !== want_wi) begin
        failures++;
        $display("FAIL inv_elem %0d got wr=%h wi=%h want wr=%h wi=%h",
                 i, cap_wr[i], cap_wi[i], exp_wr[i], want_wi);
      end
    end
    checks++;
    if (cap_wi[5] !== 32'h3ec3_ef15 || cap_wi[10] !== 32'h3f80_0000 || cap_wi[15] !== 32'hbec3_ef15) begin
      failures++;
      $display("FAIL inv_spot wi5=%h wi10=%h wi15=%h want 3ec3ef15 3f800000 bec3ef15",
               cap_wi[5], cap_wi[10], cap_wi[15]);
    end
  endtask

  task automatic test_backpressure;
    do_frame(1'b0, 6, 3, 1'b0, 1'b0, 3'd0, 32'h0);
    checks++;
    if (cap_n != 16) begin
      failures++;
      $display("FAIL bp_count got=%0d want=16", cap_n);
    end
    for (int i = 0; i < 16 && i < cap_n; i++) begin
      checks++;
      if (cap_idx[i] !== 4'(i) || cap_wr[i] !== exp_wr[i] || cap_wi[i] !== exp_wi[i]) begin
        failures++;
        $display("FAIL bp_elem %0d got idx=%0d wr=%h wi=%h want idx=%0d wr=%h wi=%h",
                 i, cap_idx[i], cap_wr[i], cap_wi[i], i, exp_wr[i], exp_wi[i]);
      end
    end
    checks++;
    if (stall_n != 3) begin
      failures++;
      $display("FAIL bp_stall_cycles got=%0d want=3", stall_n);
    end
    for (int i = 0; i < stall_n; i++) begin
      checks++;
      if (stall_idx[i] !== 4'd6 || stall_wr[i] !== exp_wr[6] || stall_wi[i] !== exp_wi[6]) begin
        failures++;
        $display("FAIL bp_hold %0d got idx=%0d wr=%h wi=%h want idx=6 wr=%h wi=%h",
                 i, stall_idx[i], stall_wr[i], stall_wi[i], exp_wr[6], exp_wi[6]);
      end
    end
    checks++;
    if (fall_cyc != t0 + 21) begin
      failures++;
      $display("FAIL bp_busy_fall got=t+%0d want=t+21", fall_cyc - t0);
    end
  endtask

  task automatic test_hazards;
    bit extra;
    do_frame(1'b0, -1, 0, 1'b1, 1'b0, 3'd0, 32'h0);
    checks++;
    if (cap_n != 16 || fall_cyc != t0 + 18) begin
      failures++;
      $display("FAIL hz_frame count=%0d fall=t+%0d want 16 and t+18", cap_n, fall_cyc - t0);
    end
    for (int i = 0; i < 16 && i < cap_n; i++) begin
      checks++;
      if (cap_idx[i] !== 4'(i) || cap_wr[i] !== exp_wr[i] || cap_wi[i] !== exp_wi[i]) begin
        failures++;
        $display("FAIL hz_elem %0d got idx=%0d wr=%h wi=%h want idx=%0d wr=%h wi=%h",
                 i, cap_idx[i], cap_wr[i], cap_wi[i], i, exp_wr[i], exp_wi[i]);
      end
    end
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      if (a_busy || a_out_valid) extra = 1;
      @(negedge clk);
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL hz_no_restart got busy/valid activity=%0d want=0", extra);
    end
    do_frame(1'b0, -1, 0, 1'b0, 1'b0, 3'd0, 32'h0);
    checks++;
    if (cap_wr[5] !== 32'h3f6c_835e || cap_wi[7] !== 32'hbf6c_835e) begin
      failures++;
      $display("FAIL hz_table_kept wr5=%h wi7=%h want 3f6c835e bf6c835e", cap_wr[5], cap_wi[7]);
    end
  endtask

  task automatic test_write_with_start;
    do_frame(1'b0, -1, 0, 1'b0, 1'b1, 3'd0, 32'h3f00_0000);
    checks++;
    if (cap_wr[0] !== 32'h3f00_0000 || cap_wr[12] !== 32'h3f00_0000 || cap_wi[10] !== 32'hbf00_0000) begin
      failures++;
      $display("FAIL wr_start wr0=%h wr12=%h wi10=%h want 3f000000 3f000000 bf000000",
               cap_wr[0], cap_wr[12], cap_wi[10]);
    end
    load_a(3'd0, 32'h3f80_0000);
  endtask

  task automatic test_reset_mid;
    bit seen;
    @(negedge clk);
    a_start = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      if (a_out_valid && a_out_idx == 4'd8) seen = 1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL rst_mid_reach idx8 not presented within budget");
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (a_busy !== 1'b0 || a_out_valid !== 1'b0 || a_out_last !== 1'b0 ||
        a_out_wr !== 32'h0 || a_out_wi !== 32'h0 || a_out_idx !== 4'h0) begin
      failures++;
      $display("FAIL rst_mid_outputs busy=%b valid=%b last=%b wr=%h wi=%h idx=%0d want all 0",
               a_busy, a_out_valid, a_out_last, a_out_wr, a_out_wi, a_out_idx);
    end
    do_frame(1'b0, -1, 0, 1'b0, 1'b0, 3'd0, 32'h0);
    checks++;
    if (cap_n != 16 || fall_cyc != t0 + 18) begin
      failures++;
      $display("FAIL rst_mid_frame count=%0d fall=t+%0d want 16 and t+18", cap_n, fall_cyc - t0);
    end
    for (int i = 0; i < 16 && i < cap_n; i++) begin
      checks++;
      if (cap_idx[i] !== 4'(i) || cap_wr[i] !== exp_wr[i] || cap_wi[i] !== exp_wi[i]) begin
        failures++;
        $display("FAIL rst_mid_elem %0d got idx=%0d wr=%h wi=%h want idx=%0d wr=%h wi=%h",
                 i, cap_idx[i], cap_wr[i], cap_wi[i], i, exp_wr[i], exp_wi[i]);
      end
    end
  endtask

  task automatic test_sweep;
    int n, m;
    bit done;
    logic [31:0] want_wr, want_wi;
    real ang;
    for (int r = 0; r <= 16; r++) begin
      @(negedge clk);
      b_tbl_we = 1'b1; b_tbl_addr = 5'(r);
      b_tbl_data = to_single($cos(2.0 * PI * r / 64.0));
    end
    @(negedge clk);
    b_tbl_we = 1'b0;
    b_start = 1'b1; b_inverse = 1'b0; b_out_ready = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    n = 0; done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      b_out_ready = (k % 3 != 2);
      if (b_out_valid && b_out_ready) begin
        m       = ((n >> 3) * (n & 7)) % 64;
        ang     = 2.0 * PI * m / 64.0;
        want_wr = to_single($cos(ang));
        want_wi = to_single(-$sin(ang));
        checks++;
        if (b_out_idx !== 6'(n) || b_out_wr !== want_wr || b_out_wi !== want_wi
            || b_out_last !== (n == 63)) begin
          failures++;
          $display("FAIL sweep_elem %0d got idx=%0d wr=%h wi=%h last=%b want wr=%h wi=%h",
                   n, b_out_idx, b_out_wr, b_out_wi, b_out_last, want_wr, want_wi);
        end
        if (b_out_last) done = 1;
        n++;
      end
      @(negedge clk);
    end
    b_out_ready = 1'b1;
    checks++;
    if (n != 64 || b_busy !== 1'b0) begin
      failures++;
      $display("FAIL sweep_frame count=%0d busy=%b want 64 and 0", n, b_busy);
    end
  endtask

  initial begin
    exp_wr = '{32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h3f800000,
               32'h3f800000, 32'h3f6c835e, 32'h3f3504f3, 32'h3ec3ef15,
               32'h3f800000, 32'h3f3504f3, 32'h00000000, 32'hbf3504f3,
               32'h3f800000, 32'h3ec3ef15, 32'hbf3504f3, 32'hbf6c835e};
    exp_wi = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
               32'h00000000, 32'hbec3ef15, 32'hbf3504f3, 32'hbf6c835e,
               32'h00000000, 32'hbf3504f3, 32'hbf800000, 32'hbf3504f3,
               32'h00000000, 32'hbf6c835e, 32'hbf3504f3, 32'h3ec3ef15};
    rst = 1'b1;
    a_tbl_we = 1'b0; a_tbl_addr = '0; a_tbl_data = '0;
    a_start = 1'b0; a_inverse = 1'b0; a_out_ready = 1'b1;
    b_tbl_we = 1'b0; b_tbl_addr = '0; b_tbl_data = '0;
    b_start = 1'b0; b_inverse = 1'b0; b_out_ready = 1'b1;

    test_reset;
    load_a(3'd0, 32'h3f80_0000);
    load_a(3'd1, 32'h3f6c_835e);
    load_a(3'd2, 32'h3f35_04f3);
    load_a(3'd3, 32'h3ec3_ef15);
    load_a(3'd4, 32'h0000_0000);
    load_a(3'd5, 32'h4120_0000);
    test_forward;
    test_inverse;
    test_backpressure;
    test_hazards;
    test_write_with_start;
    test_reset_mid;
    test_sweep;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/twiddle_seq.md
# twiddle_seq

Parametrised, streaming twiddle-factor sequencer for the FFT datapath, generating W_N^(n1·k2) = cos(2π·n1·k2/N) − j·sin(2π·n1·k2/N) as IEEE-754 single-precision pairs. It covers an N = N1·N2 two-dimensional decomposition in row-major order, with n1 as the row and k2 as the column. It stores only a quarter-wave cosine table and rebuilds the full circle by quadrant symmetry. It adds start/busy control, a valid/ready output stream with backpressure, and a forward/inverse (conjugate) mode, and it feeds the twiddle multiplier between FFT passes.

## Interface
- LOG2_N, 4, log2 of transform size N; legal range 2..10
- LOG2_N2, 2, log2 of column count N2; legal range 1..LOG2_N−1; rows N1 = N/N2
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- tbl_we  in  1  write strobe for the cosine table
- tbl_addr  in  LOG2_N−1  table index r, 0..N/4
- tbl_data  in  32  cos(2πr/N), IEEE-754 single
- start  in  1  single-cycle pulse that begins one frame of N twiddles
- inverse  in  1  sampled with start; 1 = emit conjugate (+sin)
- busy  out  1  frame in progress
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts the word when out_valid && out_ready
- out_wr  out  32  real part
- out_wi  out  32  imaginary part
- out_idx  out  LOG2_N  element index n1·N2 + k2
- out_last  out  1  marks the final element of the frame (idx N−1)

## Operation
- **Cosine table:** N/4+1 words of 32 bits, register or LUT array.
  - A write occurs when tbl_we && !busy; tbl_we while busy is ignored.
  - tbl_addr > N/4 is ignored.
  - The table is not cleared by rst.
- **Counters:** row n1, column k2, and exponent accumulator e (LOG2_N bits, wraps mod N).
  - At row start e = 0. Each column step does e ← e + n1 (mod N). No multiplier.
- **Quadrant mapping:** q = e[LOG2_N−1:LOG2_N−2], r = e mod N/4, c[x] = table word x.
  - q=0: cos = c[r], sin = c[N/4−r]
  - q=1: cos = −c[N/4−r], sin = c[r]
  - q=2: cos = −c[r], sin = −c[N/4−r]
  - q=3: cos = c[N/4−r], sin = −c[r]
- **Output values:** out_wr = cos. out_wi = −sin when forward, +sin when inverse.
  - Negation is a flip of bit 31 only.
  - Result canonicalisation: any word whose bits [30:0] are all zero is output with bit 31 = 0, so it is always 0x00000000 and never −0.
- **FSM states:** IDLE, RUN, DRAIN.
  - IDLE → RUN on start (start is ignored in RUN and DRAIN). Counters clear; inverse is latched.
  - RUN issues one element per advance. After issuing idx N−1 it moves to DRAIN.
  - DRAIN → IDLE when the last element is accepted.
- **Pipeline:** two stages.
  - S1 registers the quadrant, both table addresses, idx, last and valid.
  - S2 performs the table read, sign and canonicalisation logic, and registers the outputs.
  - Global advance enable = !out_valid || out_ready. When it is low, S1, S2 and the counters all hold.

## Timing
- **Reset values:** busy=0, out_valid=0, out_last=0, out_wr=0, out_wi=0, out_idx=0. FSM=IDLE, counters=0, inverse latch=0.
- **Start and first output:** start is sampled in IDLE at cycle t.
  - busy=1 from t+1.
  - S1 holds element 0 at t+1; out_valid=1 with element 0 at t+2.
- **Throughput:** one element per cycle while out_ready=1. A full frame with ready held high shows out_valid for N consecutive cycles, t+2..t+N+1.
- **Backpressure:** while out_valid && !out_ready, all outputs hold stable. No element is dropped or duplicated.
- **Frame end:** when out_last is accepted at cycle u, out_valid=0 and busy=0 at u+1. A new start is accepted from u+1.
- **Simultaneous events:**
  - start in the same cycle as the final acceptance is ignored, because busy is still 1.
  - tbl_we together with start in IDLE: the write completes, and the frame reads the new value.
- **Reset mid-frame:** rst at any cycle returns every output to its reset value on the next edge. Table contents are retained.

## Test plan
All tests use the defaults (N=16, N2=4). The table is loaded with c = {3f800000, 3f6c835e, 3f3504f3, 3ec3ef15, 00000000}.

- **Forward frame, ready=1:**
  - idx0–4 give wr=3f800000, wi=00000000 (no −0 on idx0).
  - idx5 gives wr=3f6c835e, wi=bec3ef15.
  - idx10 gives wr=00000000, wi=bf800000.
  - idx14 gives wr=bf3504f3, wi=bf3504f3.
  - idx15 gives wr=bf6c835e, wi=3ec3ef15, out_last=1.
  - First valid at t+2; busy falls at t+18.
- **Inverse frame:** idx5 gives wi=3ec3ef15; idx10 gives wi=3f800000; idx15 gives wi=bec3ef15. out_wr is identical to the forward frame.
- **Backpressure:** drop out_ready for 3 cycles while idx6 is presented. idx6 is held with its data stable, then idx7 follows. All 16 elements arrive in order, and busy falls 3 cycles later than in the unstalled frame.
- **Control hazards:**
  - start pulsed mid-frame and on the final-accept cycle produces no restart and no extra frame.
  - tbl_we while busy leaves the table unchanged; a read-back via the next frame's idx5 still gives 3f6c835e.
- **Reset mid-frame:** rst at idx8 gives all outputs 0 and busy=0 on the next cycle. A following start produces a complete frame from idx0 with the same table values.
- **Parameter sweep** (LOG2_N=6, LOG2_N2=3, table loaded with cos(2πr/64)): every element matches a software model of W_64^(n1·k2) bit-exactly, including canonical +0 handling.
